// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared geometry constants, pattern enum and pixel type
package vga_pkg;
  localparam int H_PIXELS   = 250;
  localparam int V_PIXELS   = 125;
  localparam int COL_BITS   = 9;
  localparam int ROW_BITS   = 8;
  localparam int COLOR_BITS = 4;
  localparam int BOX_SIZE   = 16;
  localparam int BOX_X_MAX  = H_PIXELS - BOX_SIZE;
  localparam int BOX_Y_MAX  = V_PIXELS - BOX_SIZE;

  typedef enum logic [1:0] {PAT_BARS, PAT_CHECKER, PAT_BOX, PAT_GRADIENT} pattern_e;

  typedef struct packed {
    logic [COLOR_BITS-1:0] red;
    logic [COLOR_BITS-1:0] green;
    logic [COLOR_BITS-1:0] blue;
  } rgb_t;

  function automatic logic [COLOR_BITS-1:0] rep(input logic b);
    return {COLOR_BITS{b}};
  endfunction
endpackage

// File: rtl/vga_box_tracker.sv
// rtl/vga_box_tracker.sv - bouncing-box position, one step per completed frame
module vga_box_tracker
  import vga_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_frame_end,
  output logic [COL_BITS-1:0] o_box_x,
  output logic [ROW_BITS-1:0] o_box_y
);
  localparam logic [COL_BITS-1:0] X_MAX = COL_BITS'(BOX_X_MAX);
  localparam logic [ROW_BITS-1:0] Y_MAX = ROW_BITS'(BOX_Y_MAX);

  logic [COL_BITS-1:0] r_x;
  logic [ROW_BITS-1:0] r_y;
  logic                r_x_neg;
  logic                r_y_neg;

  // A limit hit reverses direction and steps back in the same update.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_x     <= '0;
      r_y     <= '0;
      r_x_neg <= 1'b0;
      r_y_neg <= 1'b0;
    end else if (i_frame_end) begin
      if (!r_x_neg) begin
        if (r_x == X_MAX) begin
          r_x     <= r_x - 1'b1;
          r_x_neg <= 1'b1;
        end else begin
          r_x <= r_x + 1'b1;
        end
      end else begin
        if (r_x == '0) begin
          r_x     <= COL_BITS'(1);
          r_x_neg <= 1'b0;
        end else begin
          r_x <= r_x - 1'b1;
        end
      end
      if (!r_y_neg) begin
        if (r_y == Y_MAX) begin
          r_y     <= r_y - 1'b1;
          r_y_neg <= 1'b1;
        end else begin
          r_y <= r_y + 1'b1;
        end
      end else begin
        if (r_y == '0) begin
          r_y     <= ROW_BITS'(1);
          r_y_neg <= 1'b0;
        end else begin
          r_y <= r_y - 1'b1;
        end
      end
    end
  end

  assign o_box_x = r_x;
  assign o_box_y = r_y;
endmodule

// File: rtl/vga_pattern_gen.sv
// rtl/vga_pattern_gen.sv - two-stage test-pattern pixel pipeline behind the VGA timing generator
// Optional white frame border when VGA_PATTERN_BORDER_EN is defined.
module vga_pattern_gen
  import vga_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_disp_ena,
  input  logic [COL_BITS-1:0]   i_col,
  input  logic [ROW_BITS-1:0]   i_row,
  input  logic [1:0]            i_mode_req,
  output logic                  o_pix_valid,
  output logic [COLOR_BITS-1:0] o_red,
  output logic [COLOR_BITS-1:0] o_green,
  output logic [COLOR_BITS-1:0] o_blue,
  output logic [1:0]            o_mode_active,
  output logic [7:0]            o_frame_cnt
);
  localparam logic [COL_BITS-1:0] COL_LAST = COL_BITS'(H_PIXELS - 1);
  localparam logic [ROW_BITS-1:0] ROW_LAST = ROW_BITS'(V_PIXELS - 1);
  localparam logic [COL_BITS:0]   BOX_W    = (COL_BITS+1)'(BOX_SIZE);
  localparam logic [ROW_BITS:0]   BOX_H    = (ROW_BITS+1)'(BOX_SIZE);

  logic                  r_started;
  logic                  r_de_prev;
  pattern_e              r_mode;
  logic                  r_s1_valid;
  logic [COL_BITS-1:0]   r_s1_col;
  logic [ROW_BITS-1:0]   r_s1_row;
  logic                  r_s1_frame_end;
  logic [7:0]            r_frame_cnt;
  logic                  r_pix_valid;
  rgb_t                  r_rgb;

  logic                  w_frame_start;
  logic                  w_active;
  logic                  w_frame_end;
  logic [COL_BITS-1:0]   w_box_x;
  logic [ROW_BITS-1:0]   w_box_y;
  logic                  w_box_hit;
  rgb_t                  w_rgb;

  assign w_frame_start = i_disp_ena && (i_col == '0) && (i_row == '0) && !r_de_prev;
  // Nothing is drawn or counted until a frame start has been seen after reset.
  assign w_active      = r_started || w_frame_start;
  assign w_frame_end   = i_disp_ena && w_active && (i_col == COL_LAST) && (i_row == ROW_LAST);

  vga_box_tracker u_box (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_frame_end (r_s1_frame_end),
    .o_box_x     (w_box_x),
    .o_box_y     (w_box_y)
  );

  assign w_box_hit = ({1'b0, r_s1_col} >= {1'b0, w_box_x}) &&
                     ({1'b0, r_s1_col} <  {1'b0, w_box_x} + BOX_W) &&
                     ({1'b0, r_s1_row} >= {1'b0, w_box_y}) &&
                     ({1'b0, r_s1_row} <  {1'b0, w_box_y} + BOX_H);

  always_comb begin
    w_rgb = '0;
    unique case (r_mode)
      PAT_BARS: begin
        w_rgb.red   = rep(r_s1_col[5]);
        w_rgb.green = rep(r_s1_col[6]);
        w_rgb.blue  = rep(r_s1_col[7]);
      end
      PAT_CHECKER: begin
        if (r_s1_col[3] ^ r_s1_row[3]) w_rgb = '1;
      end
      PAT_BOX: begin
        if (w_box_hit) w_rgb.red  = '1;
        else           w_rgb.blue = COLOR_BITS'(4);
      end
      PAT_GRADIENT: begin
        w_rgb.red   = r_s1_col[7:4];
        w_rgb.green = r_s1_row[6:3];
        w_rgb.blue  = r_frame_cnt[3:0];
      end
    endcase
`ifdef VGA_PATTERN_BORDER_EN
    if ((r_s1_col == '0) || (r_s1_col == COL_LAST) || (r_s1_row == '0) || (r_s1_row == ROW_LAST))
      w_rgb = '1;
`endif
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_started      <= 1'b0;
      r_de_prev      <= 1'b0;
      r_mode         <= PAT_BARS;
      r_s1_valid     <= 1'b0;
      r_s1_col       <= '0;
      r_s1_row       <= '0;
      r_s1_frame_end <= 1'b0;
      r_frame_cnt    <= '0;
      r_pix_valid    <= 1'b0;
      r_rgb          <= '0;
    end else begin
      r_de_prev <= i_disp_ena;
      if (w_frame_start) begin
        r_started <= 1'b1;
        r_mode    <= pattern_e'(i_mode_req);
      end
      r_s1_valid     <= i_disp_ena && w_active;
      r_s1_col       <= i_col;
      r_s1_row       <= i_row;
      r_s1_frame_end <= w_frame_end;
      if (r_s1_frame_end) r_frame_cnt <= r_frame_cnt + 8'd1;
      r_pix_valid <= r_s1_valid;
      r_rgb       <= r_s1_valid ? w_rgb : '0;
    end
  end

  assign o_pix_valid   = r_pix_valid;
  assign o_red         = r_rgb.red;
  assign o_green       = r_rgb.green;
  assign o_blue        = r_rgb.blue;
  assign o_mode_active = r_mode;
  assign o_frame_cnt   = r_frame_cnt;
endmodule

// File: tb/tb_vga_pattern_gen.sv
// tb/tb_vga_pattern_gen.sv - scoreboard bench for vga_pattern_gen with directed pixel vectors
module tb_vga_pattern_gen;
  logic       clk;
  logic       rst;
  logic       disp_ena;
  logic [8:0] col;
  logic [7:0] row;
  logic [1:0] mode_req;
  logic       pix_valid;
  logic [3:0] red, green, blue;
  logic [1:0] mode_active;
  logic [7:0] frame_cnt;

  typedef struct {
    int       cyc;
    bit       chk;
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   nfr = 0;

  vga_pattern_gen dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_disp_ena    (disp_ena),
    .i_col         (col),
    .i_row         (row),
    .i_mode_req    (mode_req),
    .o_pix_valid   (pix_valid),
    .o_red         (red),
    .o_green       (green),
    .o_blue        (blue),
    .o_mode_active (mode_active),
    .o_frame_cnt   (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (pix_valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pixel: got valid rgb=%h%h%h at cycle %0d, required no pixel", red, green, blue, cyc);
      end else begin
        e = sb.pop_front();
        if (e.cyc != cyc) begin
          errors++;
          $display("FAIL latency: pixel at cycle %0d, required cycle %0d", cyc, e.cyc);
        end else if (e.chk && ({red, green, blue} != {e.r, e.g, e.b})) begin
          errors++;
          $display("FAIL pixel_rgb: got %h%h%h, required %h%h%h (cycle %0d)", red, green, blue, e.r, e.g, e.b, cyc);
        end
      end
    end else if ({red, green, blue} != 12'h000) begin
      checks++;
      errors++;
      $display("FAIL blank_rgb: got %h%h%h while invalid, required 000", red, green, blue);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic drive(input bit de, input int c, input int r);
    @(posedge clk);
    #1;
    disp_ena = de;
    col      = 9'(c);
    row      = 8'(r);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 0, 0);
  endtask

  task automatic px(input int c, input int r, input bit chk_en,
                    input logic [3:0] er, input logic [3:0] eg, input logic [3:0] eb);
    exp_t e;
`ifdef VGA_PATTERN_BORDER_EN
    if (c == 0 || c == 249 || r == 0 || r == 124) begin
      er = 4'hF; eg = 4'hF; eb = 4'hF;
    end
`endif
    drive(1'b1, c, r);
    e.cyc = cyc + 2;
    e.chk = chk_en;
    e.r   = er;
    e.g   = eg;
    e.b   = eb;
    sb.push_back(e);
  endtask

  task automatic start_frame(input logic [1:0] m, input bit chk_en,
                             input logic [3:0] er, input logic [3:0] eg, input logic [3:0] eb);
    drive(1'b0, 0, 0);
    mode_req = m;
    px(0, 0, chk_en, er, eg, eb);
  endtask

  task automatic end_frame(input bit chk_en,
                           input logic [3:0] er, input logic [3:0] eg, input logic [3:0] eb);
    px(249, 124, chk_en, er, eg, eb);
    drive(1'b0, 0, 0);
    nfr++;
  endtask

  initial begin
    rst = 1'b0; disp_ena = 1'b0; col = '0; row = '0; mode_req = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_pix_valid", int'(pix_valid), 0);
    chk("reset_rgb", int'({red, green, blue}), 0);
    chk("reset_mode", int'(mode_active), 0);
    chk("reset_frame_cnt", int'(frame_cnt), 0);
    rst = 1'b1;
    idle(2);

    // Box frames before a mid-frame reset
    start_frame(2'd2, 1'b1, 4'hF, 4'h0, 4'h0);
    idle(1);
    chk("mode_latch_box", int'(mode_active), 2);
    end_frame(1'b1, 4'h0, 4'h0, 4'h4);
    start_frame(2'd2, 1'b1, 4'h0, 4'h0, 4'h4);
    px(1, 1, 1'b1, 4'hF, 4'h0, 4'h0);
    px(16, 16, 1'b1, 4'hF, 4'h0, 4'h0);
    px(17, 1, 1'b1, 4'h0, 4'h0, 4'h4);
    idle(3);
    chk("frame_cnt_one", int'(frame_cnt), 1);

    rst = 1'b0;
    drive(1'b1, 50, 30);
    drive(1'b1, 51, 30);
    drive(1'b1, 52, 30);
    rst = 1'b1;
    chk("midreset_valid", int'(pix_valid), 0);
    chk("midreset_rgb", int'({red, green, blue}), 0);
    chk("midreset_mode", int'(mode_active), 0);
    chk("midreset_frame_cnt", int'(frame_cnt), 0);
    for (int c = 53; c < 61; c++) drive(1'b1, c, 30);
    drive(1'b1, 249, 124);
    idle(3);
    chk("unstarted_mode", int'(mode_active), 0);
    chk("unstarted_frame_cnt", int'(frame_cnt), 0);
    nfr = 0;

    start_frame(2'd2, 1'b1, 4'hF, 4'h0, 4'h0);
    px(16, 0, 1'b1, 4'h0, 4'h0, 4'h4);
    px(15, 15, 1'b1, 4'hF, 4'h0, 4'h0);
    px(0, 16, 1'b1, 4'h0, 4'h0, 4'h4);
    end_frame(1'b1, 4'h0, 4'h0, 4'h4);

    // Colour bars, then a mid-frame mode request
    start_frame(2'd0, 1'b1, 4'h0, 4'h0, 4'h0);
    px(40, 10, 1'b1, 4'hF, 4'h0, 4'h0);
    px(130, 5, 1'b1, 4'h0, 4'h0, 4'hF);
    px(249, 5, 1'b1, 4'hF, 4'hF, 4'hF);
    px(224, 3, 1'b1, 4'hF, 4'hF, 4'hF);
    mode_req = 2'd1;
    px(100, 20, 1'b1, 4'hF, 4'hF, 4'h0);
    px(200, 50, 1'b1, 4'h0, 4'hF, 4'hF);
    idle(2);
    chk("mode_held_midframe", int'(mode_active), 0);
    end_frame(1'b1, 4'hF, 4'hF, 4'hF);
    idle(1);
    chk("mode_held_frame_end", int'(mode_active), 0);

    start_frame(2'd1, 1'b1, 4'h0, 4'h0, 4'h0);
    px(8, 0, 1'b1, 4'hF, 4'hF, 4'hF);
    px(8, 8, 1'b1, 4'h0, 4'h0, 4'h0);
    px(0, 8, 1'b1, 4'hF, 4'hF, 4'hF);
    idle(1);
    chk("mode_checker", int'(mode_active), 1);
    end_frame(1'b1, 4'h0, 4'h0, 4'h0);
    idle(3);

    // Box bounce over 236 frames from a clean reset
    rst = 1'b0;
    idle(3);
    rst = 1'b1;
    nfr = 0;
    for (int f = 0; f < 236; f++) begin
      start_frame(2'd2, 1'b0, 4'h0, 4'h0, 4'h0);
      if (f == 109) begin
        px(109, 109, 1'b1, 4'hF, 4'h0, 4'h0);
        px(108, 109, 1'b1, 4'h0, 4'h0, 4'h4);
        px(124, 123, 1'b1, 4'hF, 4'h0, 4'h0);
        px(125, 110, 1'b1, 4'h0, 4'h0, 4'h4);
      end
      if (f == 110) begin
        px(110, 108, 1'b1, 4'hF, 4'h0, 4'h0);
        px(110, 107, 1'b1, 4'h0, 4'h0, 4'h4);
      end
      if (f == 111) begin
        px(111, 107, 1'b1, 4'hF, 4'h0, 4'h0);
        px(111, 106, 1'b1, 4'h0, 4'h0, 4'h4);
        px(126, 122, 1'b1, 4'hF, 4'h0, 4'h0);
        px(126, 123, 1'b1, 4'h0, 4'h0, 4'h4);
      end
      if (f == 234) begin
        px(234, 16, 1'b1, 4'hF, 4'h0, 4'h0);
        px(233, 16, 1'b1, 4'h0, 4'h0, 4'h4);
        px(248, 31, 1'b1, 4'hF, 4'h0, 4'h0);
        px(234, 32, 1'b1, 4'h0, 4'h0, 4'h4);
      end
      if (f == 235) begin
        px(233, 17, 1'b1, 4'hF, 4'h0, 4'h0);
        px(248, 32, 1'b1, 4'hF, 4'h0, 4'h0);
        px(232, 17, 1'b1, 4'h0, 4'h0, 4'h4);
        px(233, 33, 1'b1, 4'h0, 4'h0, 4'h4);
      end
      end_frame(1'b0, 4'h0, 4'h0, 4'h0);
    end
    idle(3);
    chk("frame_cnt_236", int'(frame_cnt), 236);

    // Gradient: blue follows the frame counter through the 255->0 wrap
    for (int g = 0; g < 24; g++) begin
      start_frame(2'd3, 1'b1, 4'h0, 4'h0, 4'(nfr & 15));
      if (g == 0) begin
        px(200, 100, 1'b1, 4'hC, 4'hC, 4'(nfr & 15));
        idle(1);
        chk("mode_gradient", int'(mode_active), 3);
      end
      end_frame(1'b1, 4'hF, 4'hF, 4'(nfr & 15));
      if (nfr == 255 || nfr == 256) begin
        idle(2);
        chk("frame_cnt_wrap", int'(frame_cnt), nfr % 256);
      end
    end
    idle(3);

    // Right-edge pixel in box mode: border white when enabled, box background otherwise
    rst = 1'b0;
    idle(3);
    rst = 1'b1;
    start_frame(2'd2, 1'b1, 4'hF, 4'h0, 4'h0);
    px(249, 60, 1'b1, 4'h0, 4'h0, 4'h4);
    px(100, 60, 1'b1, 4'h0, 4'h0, 4'h4);
    end_frame(1'b1, 4'h0, 4'h0, 4'h4);
    idle(4);
    chk("scoreboard_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
